// File: rtl/uart_pkg.sv
// Shared constants, state encoding and config decode for the oversampling UART receiver.
package uart_pkg;

    localparam int OS_RATE    = 16;
    localparam int SAMPLE_LO  = 7;
    localparam int SAMPLE_MID = 8;
    localparam int SAMPLE_HI  = 9;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        WAIT_HIGH
    } rx_state_t;

    // Stop-bit field: 0/1 select one stop bit, 2/3 select two.
    function automatic logic two_stop(input logic [1:0] stopbit);
        return stopbit[1];
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Fractional phase accumulator producing one tick per 1/16 bit time.
module uart_baud_tick #(
    parameter int CLK_FREQ_HZ = 10_000_000,
    parameter int ACC_W       = 24
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        clear,
    input  logic [16:0] baudrate,
    output logic        tick
);

    localparam logic [ACC_W-1:0] CLK_F = ACC_W'(CLK_FREQ_HZ);

    logic [ACC_W-1:0] acc;
    logic [ACC_W-1:0] inc;
    logic [ACC_W-1:0] sum;

    // Step is baudrate*16; ACC_W leaves headroom so acc+inc never wraps.
    assign inc = ACC_W'({baudrate, 4'b0000});
    assign sum = acc + inc;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            acc  <= '0;
            tick <= 1'b0;
        end else if (clear) begin
            acc  <= '0;
            tick <= 1'b0;
        end else if (sum >= CLK_F) begin
            acc  <= sum - CLK_F;
            tick <= 1'b1;
        end else begin
            acc  <= sum;
            tick <= 1'b0;
        end
    end

endmodule

// File: rtl/uart_rx_os.sv
// 16x oversampling UART receiver with majority vote, even parity and framing check.
module uart_rx_os
    import uart_pkg::*;
#(
    parameter int CLK_FREQ_HZ = 10_000_000,
    parameter int ACC_W       = 24
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        rx_i,
    input  logic [16:0] baudrate_i,
    input  logic        parity_en_i,
    input  logic [1:0]  stopbit_i,
    output logic [7:0]  rx_data_o,
    output logic        rx_valid_o,
    output logic        busy_o,
    output logic        parity_err_o,
    output logic        frame_err_o
);

    rx_state_t   state;
    rx_state_t   state_next;
    logic        rx_m;
    logic        rx_s;
    logic [3:0]  sc;
    logic [2:0]  bit_idx;
    logic [7:0]  shift;
    logic        s_lo;
    logic        s_mid;
    logic        par_flag;
    logic        stop_idx;
    logic [16:0] baud_q;
    logic        par_en_q;
    logic        two_stop_q;
    logic        tick;
    logic        vote;
    logic        bit_done;
    logic        boundary;
    logic        start_det;
    logic        valid_n;
    logic        perr_n;
    logic        ferr_n;

    uart_baud_tick #(
        .CLK_FREQ_HZ (CLK_FREQ_HZ),
        .ACC_W       (ACC_W)
    ) u_tick (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .clear    (start_det),
        .baudrate (baud_q),
        .tick     (tick)
    );

    assign vote     = (s_lo & s_mid) | (s_lo & rx_s) | (s_mid & rx_s);
    assign bit_done = tick && (sc == 4'(SAMPLE_HI));
    assign boundary = tick && (sc == 4'(OS_RATE - 1));
    assign busy_o   = (state != IDLE);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        start_det  = 1'b0;
        valid_n    = 1'b0;
        perr_n     = 1'b0;
        ferr_n     = 1'b0;
        case (state)
            IDLE: begin
                if (!rx_s) begin
                    start_det  = 1'b1;
                    state_next = START;
                end
            end
            START: begin
                if (bit_done && vote) begin
                    state_next = IDLE;
                end else if (boundary) begin
                    state_next = DATA;
                end
            end
            DATA: begin
                if (boundary && (bit_idx == 3'd7)) begin
                    state_next = par_en_q ? PARITY : STOP;
                end
            end
            PARITY: begin
                if (boundary) begin
                    state_next = STOP;
                end
            end
            STOP: begin
                // Leave at mid-stop so a back-to-back start edge is not missed.
                if (bit_done) begin
                    if (!vote) begin
                        ferr_n     = 1'b1;
                        state_next = WAIT_HIGH;
                    end else if (stop_idx == two_stop_q) begin
                        perr_n     = par_flag;
                        valid_n    = !par_flag;
                        state_next = IDLE;
                    end
                end
            end
            WAIT_HIGH: begin
                if (rx_s) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rx_m         <= 1'b1;
            rx_s         <= 1'b1;
            sc           <= '0;
            bit_idx      <= '0;
            shift        <= '0;
            s_lo         <= 1'b1;
            s_mid        <= 1'b1;
            par_flag     <= 1'b0;
            stop_idx     <= 1'b0;
            baud_q       <= '0;
            par_en_q     <= 1'b0;
            two_stop_q   <= 1'b0;
            rx_data_o    <= '0;
            rx_valid_o   <= 1'b0;
            parity_err_o <= 1'b0;
            frame_err_o  <= 1'b0;
        end else begin
            rx_m         <= rx_i;
            rx_s         <= rx_m;
            rx_valid_o   <= valid_n;
            parity_err_o <= perr_n;
            frame_err_o  <= ferr_n;
            if (valid_n) begin
                rx_data_o <= shift;
            end
            if (start_det) begin
                sc         <= '0;
                bit_idx    <= '0;
                par_flag   <= 1'b0;
                stop_idx   <= 1'b0;
                baud_q     <= baudrate_i;
                par_en_q   <= parity_en_i;
                two_stop_q <= two_stop(stopbit_i);
            end else if (tick) begin
                sc <= sc + 4'd1;
                if (sc == 4'(SAMPLE_LO)) begin
                    s_lo <= rx_s;
                end
                if (sc == 4'(SAMPLE_MID)) begin
                    s_mid <= rx_s;
                end
                if (bit_done && (state == DATA)) begin
                    shift <= {vote, shift[7:1]};
                end
                if (bit_done && (state == PARITY)) begin
                    par_flag <= (^shift) ^ vote;
                end
                if (boundary && (state == DATA)) begin
                    bit_idx <= bit_idx + 3'd1;
                end
                if (boundary && (state == STOP)) begin
                    stop_idx <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_os.sv
// Directed bench for uart_rx_os at 10 MHz / 115200 baud with hand-computed frames.
`timescale 1ns/1ps
module tb_uart_rx_os;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        rx_i;
    logic [16:0] baudrate_i;
    logic        parity_en_i;
    logic [1:0]  stopbit_i;
    logic [7:0]  rx_data_o;
    logic        rx_valid_o;
    logic        busy_o;
    logic        parity_err_o;
    logic        frame_err_o;

    uart_rx_os #(
        .CLK_FREQ_HZ (10_000_000),
        .ACC_W       (24)
    ) dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .rx_i         (rx_i),
        .baudrate_i   (baudrate_i),
        .parity_en_i  (parity_en_i),
        .stopbit_i    (stopbit_i),
        .rx_data_o    (rx_data_o),
        .rx_valid_o   (rx_valid_o),
        .busy_o       (busy_o),
        .parity_err_o (parity_err_o),
        .frame_err_o  (frame_err_o)
    );

    always #50 clk_i = ~clk_i;

    localparam int BIT_NS = 8681;

    int          vec_cnt = 0;
    int          err_cnt = 0;
    int          valid_cnt;
    int          perr_cnt;
    int          ferr_cnt;
    int          busy_cyc;
    logic [7:0]  rxq[$];
    longint      cyc = 0;
    longint      first_valid_cyc;
    longint      start_cyc;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vec_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic clear_counts();
        valid_cnt       = 0;
        perr_cnt        = 0;
        ferr_cnt        = 0;
        busy_cyc        = 0;
        first_valid_cyc = -1;
        rxq.delete();
    endtask

    // Frame on rx_i; the line is left at the last stop-bit value.
    task automatic send_frame(input logic [7:0] d, input logic par_on, input logic par_val,
                              input int nstop, input logic stop_val, input int bit_ns);
        rx_i = 1'b0;
        #(bit_ns);
        for (int i = 0; i < 8; i++) begin
            rx_i = d[i];
            #(bit_ns);
        end
        if (par_on) begin
            rx_i = par_val;
            #(bit_ns);
        end
        for (int i = 0; i < nstop; i++) begin
            rx_i = stop_val;
            #(bit_ns);
        end
    endtask

    always @(posedge clk_i) cyc++;

    always @(negedge clk_i) begin
        if (rx_valid_o) begin
            valid_cnt++;
            rxq.push_back(rx_data_o);
            if (first_valid_cyc < 0) first_valid_cyc = cyc;
        end
        if (parity_err_o) perr_cnt++;
        if (frame_err_o) ferr_cnt++;
        if (busy_o) busy_cyc++;
    end

    int          rate_ns[3] = '{8681, 8428, 8947};
    logic [7:0]  t5_exp[4]  = '{8'h00, 8'h00, 8'h10, 8'h00};
    logic [7:0]  t5_par[4]  = '{1'b0, 1'b0, 1'b1, 1'b0};
    longint      lat;
    logic [7:0]  got_b;

    initial begin
        rst_i       = 1'b1;
        rx_i        = 1'b1;
        baudrate_i  = 17'd115200;
        parity_en_i = 1'b1;
        stopbit_i   = 2'd1;
        clear_counts();
        repeat (3) @(negedge clk_i);
        check("rst_data", rx_data_o, 8'h00);
        check("rst_valid", rx_valid_o, 1'b0);
        check("rst_busy", busy_o, 1'b0);
        check("rst_perr", parity_err_o, 1'b0);
        check("rst_ferr", frame_err_o, 1'b0);
        rst_i = 1'b0;
        repeat (20) @(negedge clk_i);

        // 1: 0xA5, even parity bit 0; valid near mid-stop (~10.6 bit times)
        clear_counts();
        start_cyc = cyc;
        send_frame(8'hA5, 1'b1, 1'b0, 1, 1'b1, BIT_NS);
        #(BIT_NS);
        lat = first_valid_cyc - start_cyc;
        check("t1_valid_cnt", valid_cnt, 1);
        check("t1_data", rx_data_o, 8'hA5);
        check("t1_perr", perr_cnt, 0);
        check("t1_ferr", ferr_cnt, 0);
        check("t1_busy", busy_o, 1'b0);
        check("t1_latency_ok", (lat >= 915 && lat <= 940), 1'b1);

        // 2: 3-cycle glitch is a false start
        clear_counts();
        @(negedge clk_i);
        rx_i = 1'b0;
        repeat (3) @(negedge clk_i);
        rx_i = 1'b1;
        #(2 * BIT_NS);
        check("t2_busy_len_ok", (busy_cyc >= 45 && busy_cyc <= 65), 1'b1);
        check("t2_valid_cnt", valid_cnt, 0);
        check("t2_err_cnt", perr_cnt + ferr_cnt, 0);
        check("t2_data", rx_data_o, 8'hA5);
        check("t2_busy", busy_o, 1'b0);

        // 3: 0x3C with wrong parity bit 1
        clear_counts();
        send_frame(8'h3C, 1'b1, 1'b1, 1, 1'b1, BIT_NS);
        #(BIT_NS);
        check("t3_perr", perr_cnt, 1);
        check("t3_valid_cnt", valid_cnt, 0);
        check("t3_ferr", ferr_cnt, 0);
        check("t3_data", rx_data_o, 8'hA5);

        // 4: stop bit 0 then break; recover with 0x11 while config toggles mid-frame
        clear_counts();
        send_frame(8'h55, 1'b1, 1'b0, 1, 1'b0, BIT_NS);
        #(20 * BIT_NS);
        check("t4_ferr", ferr_cnt, 1);
        check("t4_busy_break", busy_o, 1'b1);
        check("t4_valid_cnt", valid_cnt, 0);
        check("t4_perr", perr_cnt, 0);
        rx_i = 1'b1;
        #(2 * BIT_NS);
        check("t4_busy_release", busy_o, 1'b0);
        clear_counts();
        fork
            send_frame(8'h11, 1'b1, 1'b0, 1, 1'b1, BIT_NS);
            begin
                #(3 * BIT_NS);
                baudrate_i  = 17'd57600;
                parity_en_i = 1'b0;
            end
        join
        baudrate_i  = 17'd115200;
        parity_en_i = 1'b1;
        #(BIT_NS);
        check("t4_valid_cnt2", valid_cnt, 1);
        check("t4_data", rx_data_o, 8'h11);
        check("t4_err_cnt2", perr_cnt + ferr_cnt, 0);

        // 5: two stop bits, back-to-back, nominal / +3% / -3% line rate
        stopbit_i = 2'd2;
        for (int r = 0; r < 3; r++) begin
            clear_counts();
            for (int k = 0; k < 4; k++) begin
                send_frame(t5_exp[k], 1'b1, t5_par[k][0], 2, 1'b1, rate_ns[r]);
            end
            #(2 * BIT_NS);
            check($sformatf("t5_r%0d_valid_cnt", r), valid_cnt, 4);
            check($sformatf("t5_r%0d_err_cnt", r), perr_cnt + ferr_cnt, 0);
            for (int k = 0; k < 4; k++) begin
                got_b = (k < rxq.size()) ? rxq[k] : 8'hEE;
                check($sformatf("t5_r%0d_byte%0d", r, k), got_b, t5_exp[k]);
            end
        end
        stopbit_i = 2'd1;

        // 6: load 0x81, then reset during data bit 4, then receive 0x5A
        clear_counts();
        send_frame(8'h81, 1'b1, 1'b0, 1, 1'b1, BIT_NS);
        #(BIT_NS);
        check("t6_pre_data", rx_data_o, 8'h81);
        fork
            send_frame(8'h5A, 1'b1, 1'b0, 1, 1'b1, BIT_NS);
            begin
                #(5 * BIT_NS + BIT_NS / 2);
                @(negedge clk_i);
                check("t6_busy_pre", busy_o, 1'b1);
                rst_i = 1'b1;
                @(negedge clk_i);
                check("t6_rst_data", rx_data_o, 8'h00);
                check("t6_rst_busy", busy_o, 1'b0);
                check("t6_rst_valid", rx_valid_o, 1'b0);
                check("t6_rst_perr", parity_err_o, 1'b0);
                check("t6_rst_ferr", frame_err_o, 1'b0);
                rst_i = 1'b0;
            end
        join
        rx_i = 1'b1;
        #(15 * BIT_NS);
        clear_counts();
        send_frame(8'h5A, 1'b1, 1'b0, 1, 1'b1, BIT_NS);
        #(BIT_NS);
        check("t6_valid_cnt", valid_cnt, 1);
        check("t6_data", rx_data_o, 8'h5A);
        check("t6_err_cnt", perr_cnt + ferr_cnt, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
